// File: rtl/ped_request_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ped_request_ctrl_pkg
// Purpose  : Shared definitions for the pedestrian push-button path. Holds the
//            request-controller state encoding and the default hold-counter
//            sizing, so the debouncer instance and the request controller
//            agree on counter width.
// Contents : ped_state_e          - request controller FSM states
//            LONG_DELAY_DEFAULT   - default long-press hold time (cycles)
//            CNT_W_DEFAULT        - default hold-counter width
// Revision : 1.0 - initial release
// ============================================================================
package ped_request_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_LONG  = 2'd2
  } ped_state_e;

  localparam int LONG_DELAY_DEFAULT = 5;
  localparam int CNT_W_DEFAULT      = 19;

endpackage : ped_request_ctrl_pkg
`default_nettype wire

// File: rtl/ped_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : ped_req_latch
// Purpose  : Pending pedestrian request register pair with req/ack handshake.
//            A set in the same cycle as an accepted ack wins, so a fresh
//            request immediately follows an accepted one.
// Ports    : clk_i       - system clock
//            rst_ni      - synchronous active-low reset
//            set_req_i   - latch a normal request
//            set_long_i  - latch a request and mark it as long-press
//            ack_i       - controller accepts the pending request
//            req_o       - pending request level
//            req_long_o  - pending request was upgraded by a long press
// Revision : 1.0 - initial release
// ============================================================================
module ped_req_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_req_i,
  input  logic set_long_i,
  input  logic ack_i,
  output logic req_o,
  output logic req_long_o
);

  logic req_q;
  logic req_d;
  logic req_long_q;
  logic req_long_d;
  logic ack_take;

  // An ack only means something while a request is actually pending.
  assign ack_take = req_q & ack_i;

  always_comb begin
    req_d      = set_req_i | set_long_i | (req_q & ~ack_take);
    // A plain press never clears an existing long upgrade; only an accepted
    // ack does, and a long set re-arms it regardless.
    req_long_d = set_long_i | (req_long_q & ~ack_take);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q      <= 1'b0;
      req_long_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      req_long_q <= req_long_d;
    end
  end

  assign req_o      = req_q;
  assign req_long_o = req_long_q;

endmodule : ped_req_latch
`default_nettype wire

// File: rtl/ped_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ped_request_ctrl
// Purpose  : Turns the debounced button level into one-cycle press, release
//            and long-press events, and holds a pedestrian request until the
//            light-sequencing FSM acknowledges it.
// Ports    : clk           - system clock
//            reset         - synchronous active-low reset
//            clean         - debounced button level (1 = pressed)
//            enable        - allow new requests to be latched
//            req_ack       - controller accepts the pending request
//            press_pulse   - one-cycle pulse on accepted press
//            release_pulse - one-cycle pulse on release
//            long_pulse    - one-cycle pulse when a press reaches LONG_DELAY
//            req           - pending pedestrian request
//            req_long      - pending request upgraded by a long press
//            held          - button is in a pressed state (S_PRESS/S_LONG)
// Revision : 1.0 - initial release
// ============================================================================
module ped_request_ctrl
  import ped_request_ctrl_pkg::*;
#(
  parameter int LONG_DELAY = LONG_DELAY_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clean,
  input  logic enable,
  input  logic req_ack,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic req,
  output logic req_long,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_DELAY_C = CNT_W'(LONG_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);

  ped_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic             prev_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             held_q;

  logic             rise;
  logic             press_evt;
  logic             long_evt;

  assign rise = clean & ~prev_q;

  // Same conditions the FSM uses to fire its pulses; fed to the request
  // latch so req rises in the same cycle as the corresponding pulse.
  assign press_evt = (state_q == S_IDLE) & rise;
  assign long_evt  = (state_q == S_PRESS) & clean & (count_q == LONG_DELAY_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      // Loading the live level means a button held through reset is not
      // seen as a new press.
      prev_q    <= clean;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      prev_q    <= clean;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_PRESS;
            count_q <= '0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end
        end
        S_PRESS: begin
          // Release has priority: a fall on the very cycle the count matures
          // is a release only.
          if (!clean) begin
            state_q   <= S_IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else if (count_q == LONG_DELAY_C) begin
            state_q <= S_LONG;
            long_q  <= 1'b1;
          end else begin
            count_q <= count_q + CNT_ONE_C;
          end
        end
        S_LONG: begin
          if (!clean) begin
            state_q   <= S_IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  ped_req_latch u_req_latch (
    .clk_i      (clk),
    .rst_ni     (reset),
    .set_req_i  (press_evt & enable),
    .set_long_i (long_evt & enable),
    .ack_i      (req_ack),
    .req_o      (req),
    .req_long_o (req_long)
  );

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign held          = held_q;

endmodule : ped_request_ctrl
`default_nettype wire

// File: tb/tb_ped_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_request_ctrl
// Purpose  : Directed, table-driven self-checking bench for ped_request_ctrl.
//            Each table row is the input set for one clock edge and the
//            outputs expected just after that edge, packed as
//            {press, release, long, req, req_long, held}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ped_request_ctrl;

  localparam int LONG_DELAY = 5;
  localparam int CNT_W      = 19;

  logic clk;
  logic reset;
  logic clean;
  logic enable;
  logic req_ack;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic req;
  logic req_long;
  logic held;

  int n_checks;
  int n_pass;

  typedef struct {
    logic       rst_n;
    logic       clean;
    logic       en;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  ped_request_ctrl #(
    .LONG_DELAY (LONG_DELAY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clean         (clean),
    .enable        (enable),
    .req_ack       (req_ack),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .req           (req),
    .req_long      (req_long),
    .held          (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, long_pulse, req, req_long, held};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act[5:0], exp[5:0]);
  endtask

  task automatic add(input logic r, input logic c, input logic e, input logic a,
                     input logic p, input logic rl, input logic l,
                     input logic rq, input logic rlg, input logic h);
    vec_t v;
    v.rst_n = r;
    v.clean = c;
    v.en    = e;
    v.ack   = a;
    v.exp   = {p, rl, l, rq, rlg, h};
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    clean    = 1'b0;
    enable   = 1'b1;
    req_ack  = 1'b0;

    //   rst cln en ack   P  R  L  req rlg held
    // Reset, then a short press (4 samples high) with enable, then ack.
    add(0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0,   0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0,   0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0,   0, 0, 0, 1, 0, 1);
    add(1, 0, 1, 0,   0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    // Long press: long pulse LONG_DELAY+1 edges after the press edge.
    add(1, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    for (int i = 0; i < LONG_DELAY; i++) add(1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0,   0, 0, 1, 1, 1, 1);
    add(1, 1, 1, 0,   0, 0, 0, 1, 1, 1);
    add(1, 1, 1, 1,   0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0,   0, 1, 0, 0, 0, 0);
    // Fall on the cycle count reaches LONG_DELAY: release only, no long.
    add(1, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    for (int i = 0; i < LONG_DELAY; i++) add(1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 1, 0,   0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 1,   0, 0, 0, 0, 0, 0);
    // Ack coinciding with a new press: the set wins.
    add(1, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    add(1, 0, 1, 0,   0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 1,   1, 0, 0, 1, 0, 1);
    add(1, 0, 1, 0,   0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1,   0, 0, 0, 0, 0, 0);
    // enable=0: events still fire, no request latched.
    add(1, 1, 0, 0,   1, 0, 0, 0, 0, 1);
    for (int i = 0; i < LONG_DELAY; i++) add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0,   0, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0,   0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0,   0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0,   0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    // Button held through reset: no press until released and re-pressed.
    add(0, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0,   0, 0, 0, 1, 0, 1);
    // Reset clears a pending request; enable=0 never clears one.
    add(0, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0,   1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1,   0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset   = vecs[i].rst_n;
      clean   = vecs[i].clean;
      enable  = vecs[i].en;
      req_ack = vecs[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
    end

    // Hand sequence: measure press-to-long latency with a bounded wait.
    reset   = 1'b1;
    enable  = 1'b1;
    req_ack = 1'b0;
    clean   = 1'b1;
    @(posedge clk);
    #1;
    chk("seq_press", {31'd0, press_pulse}, 32'd1);
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (long_pulse) break;
    end
    chk("seq_long_latency", n, LONG_DELAY + 1);
    chk("seq_req_long", {30'd0, req, req_long}, 32'd3);
    @(posedge clk);
    #1;
    chk("seq_long_one_cycle", {31'd0, long_pulse}, 32'd0);
    clean = 1'b0;
    @(posedge clk);
    #1;
    chk("seq_release", {29'd0, release_pulse, held, req}, 32'b101);
    req_ack = 1'b1;
    @(posedge clk);
    #1;
    req_ack = 1'b0;
    chk("seq_ack_clear", {30'd0, req, req_long}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ped_request_ctrl
`default_nettype wire
